// File: rtl/regfile_sb.sv
// regfile_sb: parametrised multi-port register file with bypass and per-register busy scoreboard
module regfile_sb #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREAD*AW-1:0]     rd_addr,
  output logic [NREAD*WIDTH-1:0]  rd_data,
  output logic [NREAD-1:0]        rd_busy,
  input  logic [NWRITE-1:0]       we,
  input  logic [NWRITE*AW-1:0]    wa,
  input  logic [NWRITE*WIDTH-1:0] wd,
  input  logic                    rsv_en,
  input  logic [AW-1:0]           rsv_addr,
  output logic                    rsv_ok,
  output logic [DEPTH-1:0]        busy_vec,
  output logic                    wr_conflict
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic             conf_q, conf_d;
  logic [NWRITE-1:0] wv;
  logic [DEPTH-1:0] wen;
  logic [WIDTH-1:0] wdat [DEPTH];

  function automatic logic valid(input logic [AW-1:0] a);
    return (32'(a) < DEPTH) && !(ZERO_REG != 0 && a == '0);
  endfunction

  // Later ports overwrite earlier ones, so the highest-index port wins.
  always_comb begin
    wen = '0;
    conf_d = 1'b0;
    for (int p = 0; p < NWRITE; p++) wv[p] = we[p] && valid(wa[p*AW +: AW]);
    for (int r = 0; r < DEPTH; r++) begin
      wdat[r] = '0;
      for (int p = 0; p < NWRITE; p++)
        if (wv[p] && wa[p*AW +: AW] == AW'(r)) begin
          wen[r] = 1'b1;
          wdat[r] = wd[p*WIDTH +: WIDTH];
        end
    end
    for (int p = 0; p < NWRITE; p++)
      for (int q = p + 1; q < NWRITE; q++)
        if (wv[p] && wv[q] && wa[p*AW +: AW] == wa[q*AW +: AW]) conf_d = 1'b1;
  end

  assign rsv_ok = rsv_en && reset && valid(rsv_addr) && !busy_q[rsv_addr];

  // A granted reservation beats a same-cycle write clearing the bit.
  always_comb
    for (int r = 0; r < DEPTH; r++)
      busy_d[r] = (rsv_ok && rsv_addr == AW'(r)) ? 1'b1 : wen[r] ? 1'b0 : busy_q[r];

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic ok, hit;
    assign a   = rd_addr[k*AW +: AW];
    assign ok  = valid(a);
    assign hit = BYPASS != 0 && reset && ok && wen[a];
    assign rd_data[k*WIDTH +: WIDTH] = !ok ? '0 : hit ? wdat[a] : mem_q[a];
    assign rd_busy[k] = ok && (hit ? busy_d[a] : busy_q[a]);
  end

  always_ff @(posedge clk)
    if (!reset) begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
      busy_q <= '0;
      conf_q <= 1'b0;
    end else begin
      for (int r = 0; r < DEPTH; r++) if (wen[r]) mem_q[r] <= wdat[r];
      busy_q <= busy_d;
      conf_q <= conf_d;
    end

  assign busy_vec    = busy_q;
  assign wr_conflict = conf_q;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard bench for regfile_sb across default, no-bypass, wide and non-power-of-2 builds
module tb_regfile_sb;
  localparam int A_RD0 = 0, A_RD1 = 1, A_BSY0 = 2, A_BSY1 = 3, A_BVEC = 4, A_CONF = 5, A_RSV = 6;
  localparam int B_RD0 = 7, B_RD1 = 8, C_RD0 = 9, C_RD1 = 10, C_RD2 = 11, D_RD0 = 12, D_RSV = 13;

  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] a_rd_addr = '0, a_wa = '0;
  logic [1:0] a_we = '0;
  logic [31:0] a_wd = '0;
  logic a_rsv_en = 1'b0;
  logic [3:0] a_rsv_addr = '0;
  logic [31:0] a_rd_data, b_rd_data;
  logic [1:0] a_rd_busy, b_rd_busy;
  logic a_rsv_ok, b_rsv_ok, a_conf, b_conf;
  logic [15:0] a_busy_vec, b_busy_vec;

  logic [14:0] c_rd_addr = '0;
  logic c_we = 1'b0;
  logic [4:0] c_wa = '0;
  logic [31:0] c_wd = '0;
  logic [95:0] c_rd_data;
  logic [2:0] c_rd_busy;
  logic c_rsv_ok, c_conf;
  logic [31:0] c_busy_vec;

  logic [4:0] d_rd_addr = '0, d_wa = '0, d_rsv_addr = '0;
  logic d_we = 1'b0, d_rsv_en = 1'b0;
  logic [15:0] d_wd = '0, d_rd_data;
  logic d_rd_busy, d_rsv_ok, d_conf;
  logic [23:0] d_busy_vec;

  regfile_sb dut_a (.clk(clk), .reset(reset), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .we(a_we), .wa(a_wa), .wd(a_wd), .rsv_en(a_rsv_en), .rsv_addr(a_rsv_addr), .rsv_ok(a_rsv_ok),
    .busy_vec(a_busy_vec), .wr_conflict(a_conf));
  regfile_sb #(.BYPASS(0)) dut_b (.clk(clk), .reset(reset), .rd_addr(a_rd_addr), .rd_data(b_rd_data),
    .rd_busy(b_rd_busy), .we(a_we), .wa(a_wa), .wd(a_wd), .rsv_en(a_rsv_en), .rsv_addr(a_rsv_addr),
    .rsv_ok(b_rsv_ok), .busy_vec(b_busy_vec), .wr_conflict(b_conf));
  regfile_sb #(.WIDTH(32), .DEPTH(32), .NREAD(3), .NWRITE(1)) dut_c (.clk(clk), .reset(reset),
    .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_busy(c_rd_busy), .we(c_we), .wa(c_wa), .wd(c_wd),
    .rsv_en(1'b0), .rsv_addr(5'd0), .rsv_ok(c_rsv_ok), .busy_vec(c_busy_vec), .wr_conflict(c_conf));
  regfile_sb #(.DEPTH(24), .NREAD(1), .NWRITE(1)) dut_d (.clk(clk), .reset(reset), .rd_addr(d_rd_addr),
    .rd_data(d_rd_data), .rd_busy(d_rd_busy), .we(d_we), .wa(d_wa), .wd(d_wd), .rsv_en(d_rsv_en),
    .rsv_addr(d_rsv_addr), .rsv_ok(d_rsv_ok), .busy_vec(d_busy_vec), .wr_conflict(d_conf));

  typedef struct {int sel; logic [31:0] v; string n;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_pass = 0;

  function automatic logic [31:0] act(input int s);
    case (s)
      A_RD0:  return 32'(a_rd_data[15:0]);
      A_RD1:  return 32'(a_rd_data[31:16]);
      A_BSY0: return 32'(a_rd_busy[0]);
      A_BSY1: return 32'(a_rd_busy[1]);
      A_BVEC: return 32'(a_busy_vec);
      A_CONF: return 32'(a_conf);
      A_RSV:  return 32'(a_rsv_ok);
      B_RD0:  return 32'(b_rd_data[15:0]);
      B_RD1:  return 32'(b_rd_data[31:16]);
      C_RD0:  return c_rd_data[31:0];
      C_RD1:  return c_rd_data[63:32];
      C_RD2:  return c_rd_data[95:64];
      D_RD0:  return 32'(d_rd_data);
      D_RSV:  return 32'(d_rsv_ok);
      default: return 'x;
    endcase
  endfunction

  always @(negedge clk)
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] v;
      e = q.pop_front();
      v = act(e.sel);
      n_chk++;
      if (v === e.v) n_pass++;
      else $display("FAIL %s: got %h expected %h", e.n, v, e.v);
    end

  task automatic ex(input int s, input logic [31:0] v, input string n);
    exp_t e;
    e.sel = s; e.v = v; e.n = n;
    q.push_back(e);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    a_we = '0; a_rsv_en = 1'b0; c_we = 1'b0; d_we = 1'b0; d_rsv_en = 1'b0;
  endtask

  initial begin
    a_rsv_en = 1'b1; a_rsv_addr = 4'd4; a_we = 2'b01; a_wa = 8'h03; a_wd = 32'hFFFF;
    ex(A_RSV, 0, "rsv_in_reset");
    nxt(); reset = 1'b1; a_rd_addr = 8'h03;
    ex(A_RD0, 0, "reset_rd"); ex(A_BSY0, 0, "reset_busy"); ex(A_BVEC, 0, "reset_bvec");
    ex(A_CONF, 0, "reset_conf"); ex(A_RSV, 0, "reset_rsvok");
    nxt(); a_we = 2'b01; a_wa = 8'h03; a_wd = 32'hBEEF; a_rd_addr = 8'h03;
    c_we = 1'b1; c_wa = 5'd31; c_wd = 32'hDEADBEEF;
    d_we = 1'b1; d_wa = 5'd25; d_wd = 16'h1234; d_rsv_en = 1'b1; d_rsv_addr = 5'd30;
    ex(A_RD0, 32'hBEEF, "bypass_beef"); ex(B_RD0, 0, "nobypass_beef"); ex(D_RSV, 0, "d_rsv_oor");
    nxt(); a_rd_addr = 8'h03; a_we = 2'b10; a_wa = 8'h00; a_wd = 32'h1234_0000;
    c_rd_addr = {5'd31, 5'd31, 5'd31}; d_we = 1'b1; d_wa = 5'd23; d_wd = 16'h5555; d_rd_addr = 5'd25;
    ex(A_RD0, 32'hBEEF, "rd_r3_p0"); ex(A_RD1, 0, "zero_bypass"); ex(A_BSY0, 0, "rd_r3_busy");
    ex(C_RD0, 32'hDEADBEEF, "c_rd0"); ex(C_RD1, 32'hDEADBEEF, "c_rd1"); ex(C_RD2, 32'hDEADBEEF, "c_rd2");
    ex(D_RD0, 0, "d_rd_oor_25");
    nxt(); a_rd_addr = {4'h5, 4'h0}; a_we = 2'b01; a_wa = 8'h05; a_wd = 32'hA5A5;
    d_rd_addr = 5'd23; d_rsv_en = 1'b1; d_rsv_addr = 5'd23;
    ex(A_RD0, 0, "zero_stored"); ex(A_RD1, 32'hA5A5, "bypass_a5a5"); ex(B_RD1, 0, "nobypass_a5a5");
    ex(D_RD0, 32'h5555, "d_rd_23"); ex(D_RSV, 1, "d_rsv_23");
    nxt(); a_we = 2'b11; a_wa = {4'h7, 4'h7}; a_wd = {16'h2222, 16'h1111}; a_rd_addr = 8'h07; d_rd_addr = 5'd24;
    ex(A_RD0, 32'h2222, "conflict_bypass"); ex(A_CONF, 0, "conf_before"); ex(D_RD0, 0, "d_rd_oor_24");
    nxt(); a_rd_addr = {4'h5, 4'h7};
    ex(A_RD0, 32'h2222, "conflict_winner"); ex(A_RD1, 32'hA5A5, "r5_stored"); ex(A_CONF, 1, "conf_pulse");
    nxt(); ex(A_CONF, 0, "conf_one_cycle");
    nxt(); a_rsv_en = 1'b1; a_rsv_addr = 4'd4; a_rd_addr = 8'h04;
    ex(A_RSV, 1, "rsv_r4"); ex(A_BSY0, 0, "r4_not_busy_yet");
    nxt(); a_rsv_en = 1'b1; a_rsv_addr = 4'd4; a_rd_addr = 8'h04;
    ex(A_RSV, 0, "rsv_r4_again"); ex(A_BVEC, 32'h0010, "bvec_r4"); ex(A_BSY0, 1, "r4_busy");
    nxt(); a_we = 2'b01; a_wa = 8'h04; a_wd = 32'h0042; a_rd_addr = 8'h04; a_rsv_en = 1'b1; a_rsv_addr = 4'd0;
    ex(A_RD0, 32'h0042, "wr_r4_bypass"); ex(A_BSY0, 0, "wr_r4_postbusy"); ex(A_RSV, 0, "rsv_r0");
    ex(A_BVEC, 32'h0010, "bvec_still_r4");
    nxt(); a_we = 2'b01; a_wa = 8'h04; a_wd = 32'h0042; a_rd_addr = 8'h04; a_rsv_en = 1'b1; a_rsv_addr = 4'd4;
    ex(A_BVEC, 0, "bvec_cleared"); ex(A_RSV, 1, "rsv_with_wr"); ex(A_RD0, 32'h0042, "wr_rsv_bypass");
    ex(A_BSY0, 1, "wr_rsv_busy");
    nxt(); a_we = 2'b11; a_wa = {4'h2, 4'h1}; a_wd = {16'h0002, 16'h0001};
    ex(A_BVEC, 32'h0010, "reserve_wins"); ex(A_RD0, 32'h0042, "r4_data");
    nxt(); a_we = 2'b11; a_wa = {4'h3, 4'h3}; a_wd = {16'h0033, 16'h0003}; a_rsv_en = 1'b1; a_rsv_addr = 4'd2;
    ex(A_RSV, 1, "rsv_r2");
    nxt(); reset = 1'b0; a_we = 2'b01; a_wa = 8'h01; a_wd = 32'hFFFF; a_rsv_en = 1'b1; a_rsv_addr = 4'd3;
    a_rd_addr = {4'h3, 4'h1};
    ex(A_RSV, 0, "rsv_forced_off"); ex(A_RD0, 32'h0001, "no_bypass_in_reset"); ex(A_RD1, 32'h0033, "r3_before_reset");
    ex(A_CONF, 1, "conf_before_reset"); ex(A_BVEC, 32'h0014, "bvec_before_reset");
    nxt(); reset = 1'b1; a_rd_addr = {4'h3, 4'h1};
    ex(A_RD0, 0, "midreset_r1"); ex(A_RD1, 0, "midreset_r3"); ex(A_BVEC, 0, "midreset_bvec");
    ex(A_CONF, 0, "midreset_conf");
    nxt(); a_rd_addr = {4'h4, 4'h2};
    ex(A_RD0, 0, "midreset_r2"); ex(A_RD1, 0, "midreset_r4"); ex(A_BSY0, 0, "midreset_busy2");
    nxt();
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d checks still pending, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read, multi-write register file with a per-register busy scoreboard. It is the next generation of the 16x16, 2-read/1-write datapath register file. It adds configurable width, depth and port counts, optional hardwired zero register, write-to-read bypass, and reserve/release tracking of pending writes for the pipelined core. It sits between decode (reads, reservations) and writeback (writes).

## Interface
- WIDTH, 16, data word width in bits.
- DEPTH, 16, number of registers, ≥2; AW = $clog2(DEPTH) is derived.
- NREAD, 2, number of read ports, ≥1.
- NWRITE, 2, number of write ports, ≥1.
- ZERO_REG, 1, if 1 register 0 reads 0 and ignores writes and reservations.
- BYPASS, 1, if 1 same-cycle write data is forwarded to reads.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low.
- rd_addr  in  NREAD*AW  read addresses; port k uses bits [k*AW +: AW].
- rd_data  out  NREAD*WIDTH  read data, combinational.
- rd_busy  out  NREAD  busy flag of the addressed register, combinational.
- we  in  NWRITE  per-port write enable.
- wa  in  NWRITE*AW  write addresses.
- wd  in  NWRITE*WIDTH  write data.
- rsv_en  in  1  reserve request.
- rsv_addr  in  AW  register to reserve.
- rsv_ok  out  1  combinational grant of the current reservation.
- busy_vec  out  DEPTH  registered busy bits.
- wr_conflict  out  1  registered pulse: previous cycle had ≥2 enabled writes to the same address.

## Operation
- Storage: DEPTH x WIDTH array, plus busy[DEPTH] and the wr_conflict flop.
- Addresses ≥ DEPTH: reads return 0 and busy 0; writes and reservations are ignored. rsv_ok is 0 for such an address.
- Write arbitration: if several enabled ports target the same address, the highest-index port wins. wr_conflict is 1 on the following cycle only.
- ZERO_REG=1, address 0:
  - rd_data is 0 and rd_busy is 0.
  - Writes are dropped and do not count toward wr_conflict.
  - rsv_ok is 0.
- Bypass (BYPASS=1 and reset=1): if a read address matches an enabled write address this cycle, rd_data is the winning write data. rd_busy shows the post-write value, i.e. 0 unless the same register is also being reserved this cycle.
- BYPASS=0: reads always return stored contents and the stored busy bit.
- Scoreboard:
  - Any enabled write to register r clears busy[r].
  - rsv_ok = rsv_en & reset & address valid & !(ZERO_REG & addr==0) & !busy[rsv_addr].
  - rsv_ok sets busy[rsv_addr].
  - A reservation of an already-busy register is rejected (rsv_ok=0) and changes nothing.
  - Same cycle, write and granted reserve to the same r: the data is written and busy[r] ends at 1 (the reserve wins).
  - A write to a non-busy register is legal and leaves busy at 0.
- Reset (reset=0 at a rising edge): all registers become 0, busy_vec becomes 0, wr_conflict becomes 0. Writes and reservations in that cycle are discarded. rsv_ok is forced to 0 and bypass is suppressed while reset=0.

## Timing
- Read latency: 0 cycles (combinational). Write latency: data is visible in stored reads from the next cycle, and in the same cycle via bypass.
- busy_vec and wr_conflict update at the rising edge. rsv_ok is valid in the same cycle as rsv_en.
- Reset output values:
  - busy_vec = 0, wr_conflict = 0, rsv_ok = 0.
  - rd_data = 0 for all addresses from the first cycle after reset.
  - rd_busy = 0.
- Asserting reset mid-operation aborts pending reservations; no busy bit survives.

## Test plan
- Reset, then WIDTH=16/DEPTH=16: write 0xBEEF to r3 on port 0, read r3 on both ports next cycle -> rd_data = 0xBEEF on both, rd_busy = 0. Reading r3 with ZERO_REG=1 and writing r0 = 0x1234 -> r0 reads 0x0000.
- Same-cycle bypass: write r5 = 0xA5A5 while reading r5 -> rd_data = 0xA5A5 in that cycle. With BYPASS=0 the same cycle returns the old value 0x0000.
- Write conflict: port 0 writes r7 = 0x1111 and port 1 writes r7 = 0x2222 -> r7 = 0x2222 next cycle and wr_conflict = 1 for exactly one cycle.
- Scoreboard:
  - Reserve r4 -> rsv_ok = 1, busy_vec[4] = 1 next cycle.
  - Reserve r4 again -> rsv_ok = 0.
  - Write r4 = 0x0042 -> busy_vec[4] = 0 next cycle.
  - Write and reserve r4 in the same cycle -> data = 0x0042 and busy_vec[4] stays 1.
- Mid-operation reset: with r1..r3 written and r2 reserved, drive reset=0 for one edge together with a write to r1 = 0xFFFF -> all reads 0, busy_vec = 0, wr_conflict = 0.
- Parameter sweep: WIDTH=32, DEPTH=32, NREAD=3, NWRITE=1. Write r31 = 0xDEADBEEF, read it on all three ports -> all return 0xDEADBEEF. An out-of-range address on a non-power-of-2 DEPTH=24 build reads 0.
